// File: rtl/ct_spsram_512x52_ctrl.sv
// ct_spsram_512x52_ctrl
//   Access controller for one 512x52 single-port SRAM macro. After reset it
//   zero-fills the whole array, then serves read/write requests over a
//   valid/ready handshake. Read data returns in order through a 2-entry
//   response FIFO, so response backpressure never drops SRAM data.
//
// Ports
//   forever_cpuclk, cpurst_b      : clock, async active-low reset
//   req_vld/req_rdy               : request handshake
//   req_wr, req_addr              : 1=write / 0=read, word address
//   req_wdata, req_wmask          : write data, per-bit write enable (active-high)
//   rsp_vld/rsp_rdy, rsp_rdata    : read response handshake and data
//   init_done                     : array clear finished
//   sram_A/CEN/GWEN/D/WEN, sram_Q : SRAM macro interface (active-low controls)
module ct_spsram_512x52_ctrl #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 52,
   parameter int RSP_DEPTH  = 2
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_A,
   output logic                  sram_CEN,
   output logic                  sram_GWEN,
   output logic [DATA_WIDTH-1:0] sram_D,
   output logic [DATA_WIDTH-1:0] sram_WEN,
   input  logic [DATA_WIDTH-1:0] sram_Q
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                                state, state_nxt;
   logic [ADDR_WIDTH-1:0]                 init_cnt;
   logic                                  inflight;     // read issued last cycle, Q valid now
   logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0]  rsp_buf;
   logic                                  wr_ptr, rd_ptr;
   logic [1:0]                            count;

   logic fire, rd_fire, wr_fire, push, pop;

   assign fire    = req_vld & req_rdy;
   assign rd_fire = fire & ~req_wr;
   // a write with an all-zero mask is accepted but never touches the macro
   assign wr_fire = fire & req_wr & (|req_wmask);
   assign push    = inflight;
   assign rsp_vld = (count != 2'd0);
   assign pop     = rsp_vld & rsp_rdy;

   assign rsp_rdata = rsp_buf[rd_ptr];
   assign init_done = (state == ST_RUN);

   // Occupancy is taken after this cycle's pop so a continuously drained
   // buffer sustains one read per cycle; the entry freed by the pop covers
   // the read issued now. pop never exceeds count, so this cannot wrap.
   assign req_rdy = (state == ST_RUN) &&
                    ((count + {1'b0, inflight} - {1'b0, pop}) < 2'd2);

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) state <= ST_INIT;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sram_CEN  = 1'b1;
      sram_GWEN = 1'b1;
      sram_WEN  = '1;
      sram_A    = '0;
      sram_D    = '0;
      case (state)
         ST_INIT: begin
            // gated by reset so the macro sees no access while reset is held
            if (cpurst_b) begin
               sram_CEN  = 1'b0;
               sram_GWEN = 1'b0;
               sram_WEN  = '0;
               sram_A    = init_cnt;
            end
            if (init_cnt == {ADDR_WIDTH{1'b1}}) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (rd_fire) begin
               sram_CEN = 1'b0;
               sram_A   = req_addr;
            end else if (wr_fire) begin
               sram_CEN  = 1'b0;
               sram_GWEN = 1'b0;
               sram_A    = req_addr;
               sram_D    = req_wdata;
               sram_WEN  = ~req_wmask;
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         init_cnt <= '0;
         inflight <= 1'b0;
      end else begin
         if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
         inflight <= rd_fire;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rsp_buf <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (push) begin
            rsp_buf[wr_ptr] <= sram_Q;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule
